// File: rtl/lutram_stream_reader.sv
// Read engine for LUTRAM port B: streams `length` words from `base_addr`
// (wrapping at DEPTH-1) onto a valid/ready stream through a credit-limited skid FIFO.
//
// Ports:
//   clk, rst (async, active-low)
//   start/base_addr/length  : transfer request, accepted only when idle
//   busy/done               : transfer status; done pulses once per transfer
//   mem_enb/mem_addrb       : port-B read request
//   mem_doutb               : port-B read data, RD_LAT cycles after mem_enb
//   m_valid/m_ready/m_data/m_last : output stream
module lutram_stream_reader #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 200,
    parameter int DEPTH      = 8000,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              mem_enb,
    output logic [ADDR_W-1:0] mem_addrb,
    input  logic [DATA_W-1:0] mem_doutb,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   rem_q, rem_d;
    logic [RD_LAT-1:0]   pipe_v_q, pipe_v_d;
    logic [RD_LAT-1:0]   pipe_l_q, pipe_l_d;
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;

    logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
    logic                fifo_last_q [FIFO_DEPTH];

    logic                cap_v;
    logic                cap_l;
    logic                fifo_nonempty;
    logic                hs;
    logic                push;
    logic                pop;
    logic                issue;
    logic                credit_ok;
    logic [CNT_W:0]      occupancy;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Datapath and stream view. A word arriving from memory while the FIFO
    // is empty is presented directly, so the stream sees data in the same
    // cycle the read completes; it only lands in the FIFO if not taken.
    always_comb begin
        cap_v         = pipe_v_q[RD_LAT-1];
        cap_l         = pipe_l_q[RD_LAT-1];
        fifo_nonempty = (count_q != '0);

        m_valid = fifo_nonempty | cap_v;
        m_data  = '0;
        m_last  = 1'b0;
        if (fifo_nonempty) begin
            m_data = fifo_data_q[rd_ptr_q];
            m_last = fifo_last_q[rd_ptr_q];
        end else if (cap_v) begin
            m_data = mem_doutb;
            m_last = cap_l;
        end

        hs   = m_valid & m_ready;
        pop  = hs & fifo_nonempty;
        push = cap_v & ~(hs & ~fifo_nonempty);

        // Every read in flight already owns a FIFO slot, so a capture can
        // never find the FIFO full.
        occupancy = {1'b0, inflight_q} + {1'b0, count_q};
        credit_ok = (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
        issue     = (state_q == S_ISSUE) && (rem_q != '0) && credit_ok;

        mem_enb   = issue;
        mem_addrb = addr_q;
        busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        done      = (state_q == S_DONE);
    end

    // Control FSM
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d = S_ISSUE;
                        addr_d  = base_addr;
                        rem_d   = length;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    addr_d = (addr_q == ADDR_W'(DEPTH - 1)) ? '0
                                                             : addr_q + ADDR_W'(1);
                    rem_d  = rem_q - ADDR_W'(1);
                    if (rem_q == ADDR_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end else if (rem_q == '0) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Words leave in issue order, so the handshake of the word
                // tagged last means nothing remains in flight or queued.
                if (hs && m_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read-latency tracking and FIFO bookkeeping
    always_comb begin
        pipe_v_d    = '0;
        pipe_l_d    = '0;
        pipe_v_d[0] = issue;
        pipe_l_d[0] = issue && (rem_q == ADDR_W'(1));
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_v_d[i] = pipe_v_q[i-1];
            pipe_l_d[i] = pipe_l_q[i-1];
        end
        inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(cap_v);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            pipe_v_q   <= '0;
            pipe_l_q   <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            pipe_v_q   <= pipe_v_d;
            pipe_l_q   <= pipe_l_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage needs no reset: it is only observed through count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_doutb;
            fifo_last_q[wr_ptr_q] <= cap_l;
        end
    end

endmodule
